block_put: RTL and testbench
============================

Name: block_put

Overview:
Writes a J x K tile back into a row-major flattened matrix buffer; the write-side counterpart of the block extractor.
- On a start pulse it latches the tile and coordinates.
- It then walks the tile row-major, one element per cycle, and issues valid/ready write requests to the buffer's write port.
- Elements falling outside the matrix are skipped.
- Sits between the tile compute/accumulate stage and the matrix buffer memory.

Parameters:
DATA_W, 16, element width in bits
J, 2, tile rows
K, 2, tile columns
ADDR_W, 10, buffer address width; also width of coordinate and size inputs

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
start_row  input  ADDR_W  tile origin row
start_col  input  ADDR_W  tile origin column
num_cols  input  ADDR_W  matrix column count
matrix_len  input  ADDR_W  total matrix elements (rows = matrix_len / num_cols)
block_flat  input  J*K*DATA_W  tile; element i*K+j occupies bits [(i*K+j)*DATA_W +: DATA_W]
wr_en  output  1  write request valid
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
wr_ready  input  1  buffer accepts write when wr_en && wr_ready at clk edge
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse when tile finished

Behaviour:
- Reset: state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; internal i/j counters=0, latched regs=0.
- States: IDLE, SETUP, RUN, FIN.
- IDLE:
  - done=0.
  - On start=1: latch start_row, start_col, num_cols, matrix_len and block_flat, then go to SETUP.
  - Inputs may change freely afterwards.
- SETUP (1 cycle):
  - Register num_rows = matrix_len / num_cols, integer, unsigned.
  - If num_cols==0, num_rows=0.
  - Set i=j=0; busy=1; go to RUN.
- RUN: one tile element per step, current element (i,j).
  - In bounds iff (start_row+i) < num_rows AND (start_col+j) < num_cols.
  - Compare at ADDR_W+2 bits so there is no wrap.
  - In bounds:
    - Drive wr_en=1, wr_addr=((start_row+i)*num_cols + start_col+j) truncated to ADDR_W, wr_data=element i*K+j.
    - Hold all three stable until a cycle with wr_ready=1.
    - Advance on that edge.
  - Out of bounds:
    - wr_en=0 for exactly one cycle, then advance.
    - No request is issued; wr_addr/wr_data are don't-care but must not glitch wr_en.
  - Advance order: j increments; at j==K-1, j=0 and i increments.
  - After element (J-1,K-1) completes, go to FIN.
- FIN:
  - done=1 for exactly one cycle, busy=0, wr_en=0.
  - Return to IDLE.
  - A start in this cycle is ignored.
- Latency: all in bounds with wr_ready tied high gives start edge -> first wr_en = 2 cycles; J*K consecutive write cycles; done asserted the cycle after the last accepted write.
- Total busy cycles = J*K + stall cycles.
- start while busy or in FIN: ignored; no re-latch.
- wr_ready while wr_en=0: ignored.
- Reset mid-operation: immediate return to IDLE. Pending writes are abandoned and no done is issued.
- Write ordering is strictly row-major. No two requests overlap.

Optional Feature:
BLOCK_PUT_SKIP_CNT_EN
- Defined:
  - Adds output skip_cnt, width $clog2(J*K+1).
  - Cleared on reset and on accepted start.
  - Increments once per out-of-bounds element.
  - Holds its final value after done until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- J=K=2, start_row=0, start_col=0, num_cols=4, matrix_len=16, block={A,B,C,D}, wr_ready=1 -> writes (0,A),(1,B),(4,C),(5,D) on consecutive cycles starting 2 cycles after start; done 1 cycle after last write; skip_cnt=0.
- Same but start_row=3, start_col=3 -> single write (15,A); three cycles wr_en=0; done on the 5th RUN/FIN cycle; skip_cnt=3.
- Tile (0,0) with wr_ready low for 3 cycles at element B -> wr_addr=1/wr_data=B held stable for 4 cycles; sequence otherwise unchanged; busy spans J*K+3 cycles.
- num_cols=0, matrix_len=16 -> no wr_en ever; done after 4 RUN cycles; skip_cnt=4.
- start pulsed again during RUN with different block_flat -> ignored; original data written; exactly one done.
- rst asserted after second write accepted -> wr_en, busy and done go 0 immediately; no further writes; a new start after release runs a full clean tile.

Source files
------------

// File: rtl/block_put.sv
// block_put: writes a J x K tile into a row-major flattened matrix buffer over a
// valid/ready write port, skipping elements outside the matrix. Define
// BLOCK_PUT_SKIP_CNT_EN to add the skip_cnt output (count of skipped elements).
module block_put #(
    parameter int DATA_W = 16,
    parameter int J      = 2,
    parameter int K      = 2,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_row,
    input  logic [ADDR_W-1:0]       start_col,
    input  logic [ADDR_W-1:0]       num_cols,
    input  logic [ADDR_W-1:0]       matrix_len,
    input  logic [J*K*DATA_W-1:0]   block_flat,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_ready,
    output logic                    busy,
`ifdef BLOCK_PUT_SKIP_CNT_EN
    output logic [$clog2(J*K+1)-1:0] skip_cnt,
`endif
    output logic                    done
);

    localparam int IW = (J > 1) ? $clog2(J) : 1;
    localparam int JW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = ADDR_W + 2;
    localparam int SW = $clog2(J*K+1);
    localparam logic [IW-1:0] I_LAST = IW'(J - 1);
    localparam logic [JW-1:0] J_LAST = JW'(K - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic [ADDR_W-1:0]       row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0]       ncols_q, ncols_d, mlen_q, mlen_d;
    logic [ADDR_W-1:0]       nrows_q, nrows_d;
    logic [J*K*DATA_W-1:0]   block_q, block_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef BLOCK_PUT_SKIP_CNT_EN
    logic [SW-1:0]           skip_q, skip_d;
`endif

    logic [DATA_W-1:0]       tile_s [J][K];
    logic [ADDR_W-1:0]       nrows_calc_s;
    logic [ADDR_W-1:0]       nrows_sel_s;
    logic [IW-1:0]           tgt_i_s;
    logic [JW-1:0]           tgt_j_s;
    logic [CW-1:0]           row_sum_s, col_sum_s;
    logic                    tgt_inb_s;
    logic [ADDR_W-1:0]       tgt_addr_s;
    logic [DATA_W-1:0]       tgt_data_s;

    for (genvar gr = 0; gr < J; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            assign tile_s[gr][gc] = block_q[(gr*K+gc)*DATA_W +: DATA_W];
        end
    end

    assign nrows_calc_s = (ncols_q == {ADDR_W{1'b0}}) ? {ADDR_W{1'b0}} : (mlen_q / ncols_q);

    // Element the output registers present next: (0,0) out of SETUP, otherwise the row-major successor.
    always_comb begin
        tgt_i_s     = i_q;
        tgt_j_s     = j_q;
        nrows_sel_s = nrows_q;
        if (state_q == ST_SETUP) begin
            tgt_i_s     = {IW{1'b0}};
            tgt_j_s     = {JW{1'b0}};
            nrows_sel_s = nrows_calc_s;
        end else if (j_q == J_LAST) begin
            tgt_i_s = i_q + IW'(1);
            tgt_j_s = {JW{1'b0}};
        end else begin
            tgt_j_s = j_q + JW'(1);
        end
    end

    // Bounds are compared two bits wider than the address so origin + offset cannot wrap.
    assign row_sum_s  = CW'(row_q) + CW'(tgt_i_s);
    assign col_sum_s  = CW'(col_q) + CW'(tgt_j_s);
    assign tgt_inb_s  = (row_sum_s < CW'(nrows_sel_s)) && (col_sum_s < CW'(ncols_q));
    assign tgt_addr_s = row_sum_s[ADDR_W-1:0] * ncols_q + col_sum_s[ADDR_W-1:0];
    assign tgt_data_s = tile_s[tgt_i_s][tgt_j_s];

    // Next-state and next-output logic for the tile walk.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        row_d     = row_q;
        col_d     = col_q;
        ncols_d   = ncols_q;
        mlen_d    = mlen_q;
        nrows_d   = nrows_q;
        block_d   = block_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef BLOCK_PUT_SKIP_CNT_EN
        skip_d    = skip_q;
`endif
        case (state_q)
            ST_IDLE: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    row_d   = start_row;
                    col_d   = start_col;
                    ncols_d = num_cols;
                    mlen_d  = matrix_len;
                    block_d = block_flat;
`ifdef BLOCK_PUT_SKIP_CNT_EN
                    skip_d  = {SW{1'b0}};
`endif
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                nrows_d   = nrows_calc_s;
                i_d       = {IW{1'b0}};
                j_d       = {JW{1'b0}};
                busy_d    = 1'b1;
                wr_en_d   = tgt_inb_s;
                wr_addr_d = tgt_addr_s;
                wr_data_d = tgt_data_s;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                // An in-bounds element waits for wr_ready; a skipped one costs exactly one cycle.
                if (!wr_en_q || wr_ready) begin
`ifdef BLOCK_PUT_SKIP_CNT_EN
                    if (!wr_en_q) begin
                        skip_d = skip_q + SW'(1);
                    end else begin
                        skip_d = skip_q;
                    end
`endif
                    if ((i_q == I_LAST) && (j_q == J_LAST)) begin
                        wr_en_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        i_d       = tgt_i_s;
                        j_d       = tgt_j_s;
                        wr_en_d   = tgt_inb_s;
                        wr_addr_d = tgt_addr_s;
                        wr_data_d = tgt_data_s;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; rst abandons any tile in flight without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= {IW{1'b0}};
            j_q       <= {JW{1'b0}};
            row_q     <= {ADDR_W{1'b0}};
            col_q     <= {ADDR_W{1'b0}};
            ncols_q   <= {ADDR_W{1'b0}};
            mlen_q    <= {ADDR_W{1'b0}};
            nrows_q   <= {ADDR_W{1'b0}};
            block_q   <= {(J*K*DATA_W){1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BLOCK_PUT_SKIP_CNT_EN
            skip_q    <= {SW{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ncols_q   <= ncols_d;
            mlen_q    <= mlen_d;
            nrows_q   <= nrows_d;
            block_q   <= block_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BLOCK_PUT_SKIP_CNT_EN
            skip_q    <= skip_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef BLOCK_PUT_SKIP_CNT_EN
    assign skip_cnt = skip_q;
`endif

endmodule

// File: tb/tb_block_put.sv
// Directed scoreboard bench for block_put (J=K=2, DATA_W=16, ADDR_W=10).
module tb_block_put;
    localparam int DATA_W = 16;
    localparam int J      = 2;
    localparam int K      = 2;
    localparam int ADDR_W = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_W-1:0]     start_row, start_col, num_cols, matrix_len;
    logic [J*K*DATA_W-1:0] block_flat;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_ready;
    logic                  busy;
    logic                  done;
`ifdef BLOCK_PUT_SKIP_CNT_EN
    logic [2:0]            skip_cnt;
`endif

    block_put #(.DATA_W(DATA_W), .J(J), .K(K), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .start_row(start_row), .start_col(start_col),
        .num_cols(num_cols), .matrix_len(matrix_len),
        .block_flat(block_flat),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy),
`ifdef BLOCK_PUT_SKIP_CNT_EN
        .skip_cnt(skip_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [25:0] sb_q [$];
    int acc_cnt, done_cnt, busy_cnt, first_wr, last_acc, done_cyc, start_cyc;
    int exp_wr, exp_skip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set now apply at the coming edge; outputs sampled 1ns after it.
    task automatic tick();
        logic acc, p_en, p_rdy;
        logic [ADDR_W-1:0] p_addr;
        logic [DATA_W-1:0] p_data;
        logic [25:0] e;
        p_en   = wr_en;
        p_rdy  = wr_ready;
        p_addr = wr_addr;
        p_data = wr_data;
        acc    = p_en && p_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            acc_cnt++;
            last_acc = cyc;
            check("write_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(p_addr), 32'(e[25:16]));
                check("wr_data", 32'(p_data), 32'(e[15:0]));
            end
        end
        cyc++;
        if (p_en && !p_rdy && !rst && sb_q.size() > 0) begin
            check("hold_wr_en", 32'(wr_en), 32'd1);
            check("hold_wr_addr", 32'(wr_addr), 32'(sb_q[0][25:16]));
            check("hold_wr_data", 32'(wr_data), 32'(sb_q[0][15:0]));
        end
        if (wr_en && first_wr < 0) first_wr = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    endtask

    // Drive one start pulse and push the writes the tile should produce.
    task automatic start_tile(input int sr, input int sc, input int nc, input int ml,
                              input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] el [4];
        int nr, r, cl;
        el = '{a, b, c, d};
        start_row  = ADDR_W'(sr);
        start_col  = ADDR_W'(sc);
        num_cols   = ADDR_W'(nc);
        matrix_len = ADDR_W'(ml);
        block_flat = {d, c, b, a};
        nr = (nc == 0) ? 0 : ml / nc;
        exp_wr = 0;
        exp_skip = 0;
        for (int i = 0; i < J; i++) begin
            for (int j = 0; j < K; j++) begin
                r  = sr + i;
                cl = sc + j;
                if (r < nr && cl < nc) begin
                    sb_q.push_back({ADDR_W'(r * nc + cl), el[i*K+j]});
                    exp_wr++;
                end else begin
                    exp_skip++;
                end
            end
        end
        acc_cnt = 0; done_cnt = 0; busy_cnt = 0;
        first_wr = -1; last_acc = -1; done_cyc = -1;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        start_row  = ADDR_W'($urandom);
        start_col  = ADDR_W'($urandom);
        num_cols   = ADDR_W'($urandom);
        matrix_len = ADDR_W'($urandom);
        block_flat = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && done_cnt == 0; k++) tick();
        check("done_seen", 32'(done_cnt), 32'd1);
    endtask

    task automatic finish_checks(input int stalls);
        check("writes_accepted", 32'(acc_cnt), 32'(exp_wr));
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'(J*K + stalls));
        check("done_latency", 32'(done_cyc - start_cyc), 32'(2 + J*K + stalls));
        if (exp_wr > 0) check("first_wr_latency", 32'(first_wr - start_cyc), 32'd2);
        else            check("no_wr_en", 32'(first_wr), 32'hffffffff);
`ifdef BLOCK_PUT_SKIP_CNT_EN
        check("skip_cnt", 32'(skip_cnt), 32'(exp_skip));
`endif
        tick();
        tick();
        check("single_done", 32'(done_cnt), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_wr_en", 32'(wr_en), 32'd0);
`ifdef BLOCK_PUT_SKIP_CNT_EN
        check("skip_cnt_hold", 32'(skip_cnt), 32'(exp_skip));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
        start_row = '0; start_col = '0; num_cols = '0; matrix_len = '0; block_flat = '0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef BLOCK_PUT_SKIP_CNT_EN
        check("rst_skip_cnt", 32'(skip_cnt), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Tile fully inside a 4x4 matrix; a start during FIN must be ignored.
        start_tile(0, 0, 4, 16, 16'hA0A1, 16'hB0B1, 16'hC0C1, 16'hD0D1);
        wait_done();
        check("done_after_last_write", 32'(done_cyc - last_acc), 32'd1);
        start_row = '0; start_col = '0; num_cols = 10'd4; matrix_len = 10'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_checks(0);

        // Bottom-right corner: only one element lands in the matrix.
        start_tile(3, 3, 4, 16, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        wait_done();
        finish_checks(0);

        // Three stall cycles while element B is offered.
        start_tile(0, 0, 4, 16, 16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D);
        for (int k = 0; k < 10 && !(wr_en && wr_addr == 10'd1); k++) tick();
        check("stall_point", 32'(wr_addr), 32'd1);
        wr_ready = 1'b0;
        tick(); tick(); tick();
        wr_ready = 1'b1;
        wait_done();
        finish_checks(3);

        // Zero columns: every element is out of bounds.
        start_tile(0, 0, 0, 16, 16'h0F0F, 16'h1E1E, 16'h2D2D, 16'h3C3C);
        wait_done();
        finish_checks(0);

        // Non-square matrix (3 cols x 5 rows) with a re-start pulsed mid-run.
        start_tile(1, 1, 3, 15, 16'hCAFE, 16'hBEEF, 16'hF00D, 16'hD00D);
        for (int k = 0; k < 10 && !wr_en; k++) tick();
        block_flat = 64'h9999_8888_7777_6666;
        start_row = 10'd0; start_col = 10'd0; num_cols = 10'd4; matrix_len = 10'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        finish_checks(0);

        // Reset after the second accepted write abandons the tile.
        start_tile(0, 0, 4, 16, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        for (int k = 0; k < 20 && acc_cnt < 2; k++) tick();
        check("pre_reset_writes", 32'(acc_cnt), 32'd2);
        rst = 1'b1;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        sb_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("post_reset_no_writes", 32'(acc_cnt), 32'd2);
        check("post_reset_no_done", 32'(done_cnt), 32'd0);

        // Clean tile after reset, offset by one column.
        start_tile(0, 1, 4, 16, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF);
        wait_done();
        finish_checks(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
